// File: rtl/uart_rx.sv
// uart_rx
// 8N1-style serial receiver with a fixed clocks-per-bit divider.
// The serial line is synchronized, framed as start / data / stop, and each
// good word is handed out on a valid/ready interface. Framing errors and
// overruns are reported as single-cycle pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Terminal counts: the start bit is sampled half a bit in, every other
  // bit one full bit after the previous sample, which keeps samples mid-bit.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           sync_ff;
  logic                 s_data;
  logic                 word_done;
  logic                 accept;

  assign s_data = sync_ff[1];

  // A good stop bit completes the word; the output register decides
  // whether it can be delivered or must be dropped as an overrun.
  assign word_done = (state == S_STOP) && (cnt == FULL_LAST) && s_data;
  assign accept    = rx_valid && rx_ready;

  // Two-flop synchronizer for the asynchronous line, preset to idle-high
  // so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= 2'b11;
    end else begin
      sync_ff <= {sync_ff[0], data};
    end
  end

  // Frame FSM: bit timing, data shifting and the framing-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!s_data) begin
            bit_cnt <= '0;
            state   <= S_START;
          end
        end

        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= s_data ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            shreg <= {s_data, shreg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (s_data) begin
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_BREAK: begin
          cnt <= '0;
          if (s_data) begin
            state <= S_IDLE;
          end
        end

        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output holding register: a new word loads when the slot is empty or is
  // being emptied this same cycle; otherwise the new word is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Directed test of uart_rx at 16 clocks per bit with 8 data bits.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int errorCount = 0;
  int checkCount = 0;

  int          cyc = 0;
  int          fallCyc = 0;
  int          riseCyc = -1;
  logic        prevValid = 1'b0;
  logic [7:0]  words[$];
  int          frameErrCount = 0;
  int          overrunCount = 0;

  uart_rx #(
    .CLKS_PER_BIT(16),
    .DATA_BITS   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge: records accepted words, the first valid
  // rise, and the number of error pulses seen
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) words.push_back(rx_data);
      if (rx_valid && !prevValid && riseCyc < 0) riseCyc = cyc;
      if (frame_err) frameErrCount++;
      if (overrun) overrunCount++;
      prevValid = rx_valid;
    end else begin
      prevValid = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one frame: start, 8 data bits LSB first, chosen stop level
  task automatic applyStimulus(input logic [7:0] word, input logic stopBit);
    fallCyc = cyc;
    data = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      data = word[i];
      tick(16);
    end
    data = stopBit;
    tick(16);
    data = 1'b1;
  endtask

  task automatic clearMonitor();
    words.delete();
    riseCyc = -1;
    frameErrCount = 0;
    overrunCount = 0;
  endtask

  function automatic logic [31:0] wordAt(input int i);
    if (i < words.size()) return {24'h0, words[i]};
    return 32'hDEAD;
  endfunction

  initial begin
    int lat;
    rst = 1'b1;
    data = 1'b1;
    rx_ready = 1'b1;
    tick(3);
    checkOutput("reset_valid", rx_valid, 0);
    checkOutput("reset_data", rx_data, 0);
    checkOutput("reset_ferr", frame_err, 0);
    checkOutput("reset_ovr", overrun, 0);
    rst = 1'b0;
    tick(10);

    $display("[TB] single frame 0xAA");
    clearMonitor();
    applyStimulus(8'hAA, 1'b1);
    tick(20);
    checkOutput("aa_count", words.size(), 1);
    checkOutput("aa_word", wordAt(0), 32'hAA);
    checkOutput("aa_ferr", frameErrCount, 0);
    checkOutput("aa_ovr", overrunCount, 0);
    lat = riseCyc - fallCyc;
    checkOutput("aa_latency_in_154_156", (lat >= 154 && lat <= 156), 1);

    $display("[TB] back-to-back 0x33 0x3C 0x3C");
    clearMonitor();
    applyStimulus(8'h33, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    tick(20);
    checkOutput("b2b_count", words.size(), 3);
    checkOutput("b2b_w0", wordAt(0), 32'h33);
    checkOutput("b2b_w1", wordAt(1), 32'h3C);
    checkOutput("b2b_w2", wordAt(2), 32'h3C);
    checkOutput("b2b_ferr", frameErrCount, 0);

    $display("[TB] false start then 0x55");
    clearMonitor();
    data = 1'b0;
    tick(4);
    data = 1'b1;
    tick(30);
    checkOutput("glitch_count", words.size(), 0);
    checkOutput("glitch_ferr", frameErrCount, 0);
    applyStimulus(8'h55, 1'b1);
    tick(20);
    checkOutput("after_glitch_count", words.size(), 1);
    checkOutput("after_glitch_word", wordAt(0), 32'h55);

    $display("[TB] bad stop bit and held break");
    clearMonitor();
    applyStimulus(8'h0F, 1'b0);
    data = 1'b0;
    tick(40);
    data = 1'b1;
    tick(20);
    checkOutput("break_ferr", frameErrCount, 1);
    checkOutput("break_count", words.size(), 0);
    applyStimulus(8'hC3, 1'b1);
    tick(20);
    checkOutput("after_break_count", words.size(), 1);
    checkOutput("after_break_word", wordAt(0), 32'hC3);
    checkOutput("after_break_ferr", frameErrCount, 1);

    $display("[TB] overrun with consumer stalled");
    clearMonitor();
    rx_ready = 1'b0;
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    tick(20);
    checkOutput("ovr_valid_held", rx_valid, 1);
    checkOutput("ovr_data_held", rx_data, 32'h11);
    checkOutput("ovr_pulses", overrunCount, 1);
    checkOutput("ovr_ferr", frameErrCount, 0);
    rx_ready = 1'b1;
    tick(1);
    checkOutput("ovr_valid_drop", rx_valid, 0);
    tick(20);
    checkOutput("ovr_count", words.size(), 1);
    checkOutput("ovr_word", wordAt(0), 32'h11);

    $display("[TB] reset in the middle of a frame");
    clearMonitor();
    checkOutput("pre_reset_data", rx_data, 32'h11);
    data = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      data = (8'h7E >> i) & 8'h01;
      tick(16);
    end
    rst = 1'b1;
    data = 1'b1;
    #1;
    checkOutput("midrst_valid", rx_valid, 0);
    checkOutput("midrst_data", rx_data, 0);
    checkOutput("midrst_ferr", frame_err, 0);
    checkOutput("midrst_ovr", overrun, 0);
    tick(3);
    rst = 1'b0;
    tick(200);
    checkOutput("midrst_count", words.size(), 0);
    checkOutput("midrst_ferr_count", frameErrCount, 0);
    applyStimulus(8'h81, 1'b1);
    tick(20);
    checkOutput("after_rst_count", words.size(), 1);
    checkOutput("after_rst_word", wordAt(0), 32'h81);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Synthesizable 8N1-style UART receiver; the stage directly downstream of uart_tx_bfm.
- Samples the serial line with a fixed clocks-per-bit divider and validates start and stop bits.
- Delivers each received word on a valid/ready parallel interface.
- Flags framing errors and overruns as one-cycle pulses.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 4.
- DATA_BITS, 8, data bits per frame (5..9), LSB first.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- data  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  received word, valid while rx_valid=1.
- rx_valid  output  1  word available.
- rx_ready  input  1  consumer accepts word when rx_valid&&rx_ready at posedge clk.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: word completed while the previous word was unaccepted.

Behaviour:
- Reset:
  - data passes through a 2-flop synchronizer preset to 1.
  - State IDLE, counters 0, rx_data 0, rx_valid 0, frame_err 0, overrun 0.
  - Reset mid-frame abandons the frame; no valid or error is produced.
- Synchronization: all sampling uses the synchronized line (s_data); 2-cycle input latency.
- IDLE:
  - On s_data=0, clear the bit counter and move to START.
- START:
  - Count CLKS_PER_BIT/2 cycles (integer division), then sample.
  - Sample 1: false start, return to IDLE, no flags.
  - Sample 0: clear the counter and move to DATA.
- DATA:
  - Every CLKS_PER_BIT cycles, sample s_data and shift it in so the first bit lands in rx_data[0].
  - After DATA_BITS samples, move to STOP.
  - Sample points fall at mid-bit.
- STOP:
  - After CLKS_PER_BIT cycles, sample.
  - Sample 1: word complete; return to IDLE in the same cycle, which allows back-to-back frames with no idle gap.
  - Sample 0: pulse frame_err for one cycle, discard the word, move to BREAK.
- BREAK:
  - Wait until s_data=1, then go to IDLE.
  - A held-low line produces exactly one frame_err.
- Output register:
  - On word complete with rx_valid=0, load rx_data and set rx_valid=1 on the next posedge.
  - rx_valid stays high and rx_data stays stable until a cycle with rx_valid&&rx_ready; rx_valid then clears.
  - Word complete in the same cycle as an accept: the new word loads, rx_valid stays 1, no overrun.
  - Word complete with rx_valid=1 and rx_ready=0: keep the old word, drop the new one, pulse overrun for one cycle.
- Latency:
  - rx_valid rises 1 clk after the stop-bit sample.
  - That is about 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 clks after the line falls.
- Counters:
  - The bit-timing counter is sized to ceil(log2(CLKS_PER_BIT)).
  - It restarts on every state transition and never wraps while in use.

Test Plan:
- Framing of each test frame: CLKS_PER_BIT=16, rx_ready held 1; each frame is start + 8 data bits LSB-first + stop, every bit 16 clks.
- Send 0xAA -> exactly one rx_valid cycle with rx_data=0xAA, no frame_err/overrun; rx_valid rises 2+8+144+1=155 clks after the falling edge (±1).
- Send 0x33 then 0x3C,0x3C back-to-back with no idle bits -> three valids carrying 0x33, 0x3C, 0x3C in order, no errors.
- Drive data low for 4 clks, then high -> no rx_valid, no frame_err; a following 0x55 frame is received correctly.
- Send a frame with payload 0x0F whose stop bit is 0, then hold the line low for 40 clks, then release -> one frame_err pulse, no rx_valid; a next frame of 0xC3 is received as 0xC3.
- rx_ready=0, send 0x11 then 0x22 -> rx_valid held with 0x11, overrun pulses once at the second stop sample; raise rx_ready -> 0x11 accepted, rx_valid drops, 0x22 never appears.
- Assert rst for 3 clks in the middle of the DATA bits of 0x7E -> outputs 0 during reset, no valid/error for that frame; the next frame 0x81 is received as 0x81.
